// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared defaults, the full-adder cell and a configuration
// check for the pipelined add/subtract unit.
//   DEF_WIDTH  - default operand/result width
//   DEF_STAGES - default number of pipeline ranks (= latency in cycles)
//   full_add() - one-bit full adder, returns {carry, sum}
//   cfg_ok()   - 1 when WIDTH splits evenly into STAGES ripple chunks
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle of pipe_adder.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; a producer holds its payload stable while valid && !ready, and
// ready may depend combinationally on the far side's ready.
//   master - operand producer / result consumer (drives flush, in_valid, a,
//            b, cin, sub, out_ready)
//   slave  - the adder (drives in_ready, out_valid, sum, cout, ovf)
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output flush, in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  flush, in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/pipe_adder_rca_chunk.sv
// rca_chunk: N-bit ripple-carry segment built from the full-adder cell.
//   a, b - N-bit operands
//   cin  - carry into bit 0
//   sum  - N-bit sum
//   cout - carry out of bit N-1
module rca_chunk
    import pipe_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // The carry ripples through a block-local variable so the chain is one
    // combinational process rather than a self-referencing vector.
    always_comb begin
        logic       carry;
        logic [1:0] fa;
        sum   = '0;
        carry = cin;
        for (int i = 0; i < N; i++) begin
            fa     = full_add(a[i], b[i], carry);
            sum[i] = fa[0];
            carry  = fa[1];
        end
        cout = carry;
    end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit add/subtract, STAGES ranks of WIDTH/STAGES
// bits each, with the inter-chunk carry registered.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears valid bits and data
//   bus   - pipe_adder_if.slave: flush, operand handshake (in_valid/in_ready,
//           a, b, cin, sub) and result handshake (out_valid/out_ready, sum,
//           cout, ovf). Latency is STAGES cycles, throughput one per cycle.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_adder_if.slave  bus
);

    localparam int CHUNK = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    // Rank registers; index j is rank j. Operands are stored pre-shifted so
    // the next chunk to add always sits in the low CHUNK bits.
    logic             vld_q [1:STAGES];
    logic [WIDTH-1:0] sum_q [1:STAGES];
    logic [WIDTH-1:0] opa_q [1:STAGES];
    logic [WIDTH-1:0] opb_q [1:STAGES];
    logic             cy_q  [1:STAGES];
    logic             sa_q  [1:STAGES];
    logic             sb_q  [1:STAGES];

    // Sources feeding rank j+1: index 0 is the input port, index j is rank j.
    logic             vld_src [0:STAGES-1];
    logic [WIDTH-1:0] sum_src [0:STAGES-1];
    logic [WIDTH-1:0] opa_src [0:STAGES-1];
    logic [WIDTH-1:0] opb_src [0:STAGES-1];
    logic             cy_src  [0:STAGES-1];
    logic             sa_src  [0:STAGES-1];
    logic             sb_src  [0:STAGES-1];

    logic             rdy     [1:STAGES+1];
    logic [CHUNK-1:0] csum    [0:STAGES-1];
    logic             ccout   [0:STAGES-1];
    logic [WIDTH-1:0] sum_nxt [1:STAGES];

    // Subtract is a + ~b + 1: invert b and force the carry-in.
    always_comb begin
        logic [WIDTH-1:0] b_eff;
        b_eff      = bus.sub ? ~bus.b : bus.b;
        vld_src[0] = bus.in_valid;
        sum_src[0] = '0;
        opa_src[0] = bus.a;
        opb_src[0] = b_eff;
        cy_src[0]  = bus.sub | bus.cin;
        sa_src[0]  = bus.a[WIDTH-1];
        sb_src[0]  = b_eff[WIDTH-1];
        for (int j = 1; j < STAGES; j++) begin
            vld_src[j] = vld_q[j];
            sum_src[j] = sum_q[j];
            opa_src[j] = opa_q[j];
            opb_src[j] = opb_q[j];
            cy_src[j]  = cy_q[j];
            sa_src[j]  = sa_q[j];
            sb_src[j]  = sb_q[j];
        end
    end

    // A rank can take new data when it is empty or its content moves on.
    always_comb begin
        rdy[STAGES+1] = bus.out_ready;
        for (int j = STAGES; j >= 1; j--) begin
            rdy[j] = !vld_q[j] || rdy[j+1];
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_chunk
        rca_chunk #(.N(CHUNK)) u_chunk (
            .a    (opa_src[j][CHUNK-1:0]),
            .b    (opb_src[j][CHUNK-1:0]),
            .cin  (cy_src[j]),
            .sum  (csum[j]),
            .cout (ccout[j])
        );
    end

    // Rank j keeps the low sum bits so far and adds chunk j-1 on top.
    always_comb begin
        for (int j = 1; j <= STAGES; j++) begin
            sum_nxt[j] = sum_src[j-1];
            sum_nxt[j][(j-1)*CHUNK +: CHUNK] = csum[j-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 1; j <= STAGES; j++) begin
                vld_q[j] <= 1'b0;
                sum_q[j] <= '0;
                opa_q[j] <= '0;
                opb_q[j] <= '0;
                cy_q[j]  <= 1'b0;
                sa_q[j]  <= 1'b0;
                sb_q[j]  <= 1'b0;
            end
        end else begin
            for (int j = 1; j <= STAGES; j++) begin
                if (bus.flush) begin
                    vld_q[j] <= 1'b0;
                end else if (rdy[j]) begin
                    vld_q[j] <= vld_src[j-1];
                end
                // Data may load during a flush; it is stale but never valid.
                if (rdy[j]) begin
                    sum_q[j] <= sum_nxt[j];
                    opa_q[j] <= opa_src[j-1] >> CHUNK;
                    opb_q[j] <= opb_src[j-1] >> CHUNK;
                    cy_q[j]  <= ccout[j-1];
                    sa_q[j]  <= sa_src[j-1];
                    sb_q[j]  <= sb_src[j-1];
                end
            end
        end
    end

    assign bus.in_ready  = rdy[1];
    assign bus.out_valid = vld_q[STAGES];
    assign bus.sum       = sum_q[STAGES];
    assign bus.cout      = cy_q[STAGES];
    assign bus.ovf       = (sa_q[STAGES] == sb_q[STAGES]) &&
                           (sum_q[STAGES][WIDTH-1] != sa_q[STAGES]);

endmodule
